stage_debug_monitor: RTL and testbench
======================================

STAGE_DEBUG_MONITOR -- requirements
Module: stage_debug_monitor

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, the number of monitored pipeline stages (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, the statistics counter width (8..32).
REQ-003 The block SHALL have parameter DATA_W, default 32, the probed data width (1..32).
REQ-004 The block SHALL have parameter ADDR_W, default 16, the probed address width.
REQ-005 The block SHALL have parameter NUM_TRIG, default 2, the number of address-trigger capture slots (1..8).
REQ-006 The block SHALL have parameter DEBUG_ID, default 32'h4741_5401, the constant returned at register 0.
REQ-007 The block SHALL have these ports; one clock; reset is synchronous and active-high:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 clear_i  in  1  soft clear of statistics, flags and captures
 stage_vld_i  in  NUM_STAGES  per-stage start pulse
 stage_rdy_i  in  NUM_STAGES  per-stage done pulse
 probe_en_i  in  1  probe write strobe
 probe_addr_i  in  ADDR_W  probed BRAM address
 probe_data_i  in  DATA_W  probed BRAM data
 trig_addr_i  in  NUM_TRIG*ADDR_W  trigger address per slot
 cap_mode_i  in  1  0 = first-hit capture, 1 = last-hit capture
 rd_sel_i  in  8  register index
 rd_req_i  in  1  read request
 rd_vld_o  out  1  read data valid
 rd_data_o  out  32  read data
 status_o  out  2*NUM_STAGES  live sticky flags {rdy_seen, vld_seen}

Function
REQ-008 The vld_seen[s] and rdy_seen[s] flags SHALL set on the first cycle in which stage_vld_i[s] or stage_rdy_i[s], respectively, is high, and SHALL clear only on rst or clear_i.
REQ-009 Each stage SHALL run a two-state FSM: IDLE->BUSY on vld; BUSY->IDLE on rdy; vld in BUSY is ignored unless rdy is high in the same cycle.
REQ-010 When stage_vld_i[s] is high in IDLE, start_cnt[s] SHALL increment.
REQ-011 For vld in cycle t and rdy in cycle t+L, last_lat[s] SHALL equal L and total_busy[s] SHALL increase by L.
REQ-012 When vld and rdy are high together in BUSY, the measurement SHALL close and a new one SHALL start (start_cnt +1, next latency measured from this cycle, FSM stays BUSY).
REQ-013 When vld and rdy are high together in IDLE, the block SHALL record start_cnt +1, last_lat = 0 and stay in IDLE.
REQ-014 rdy in IDLE without vld SHALL set orphan[s] sticky and leave the counters unchanged.
REQ-015 All CNT_W counters SHALL saturate at all-ones and never wrap.
REQ-016 A free-running 32-bit cycle counter SHALL wrap, SHALL be cleared only by rst, and SHALL be unaffected by clear_i.
REQ-017 Capture slot k SHALL capture on probe_en_i with probe_addr_i == trig_addr_i[k].
REQ-018 In mode 0, slot k SHALL capture only while hit[k] = 0; in mode 1, slot k SHALL capture on every match.
REQ-019 On capture, hit[k] SHALL set; a single probe SHALL capture into all matching slots.
REQ-020 Register map (all entries zero-extended to 32 bits): 0 DEBUG_ID; 1 {orphan, rdy_seen, vld_seen}; 2 cycle counter; 3+3s start_cnt[s]; 4+3s last_lat[s]; 5+3s total_busy[s].
REQ-021 With T = 3+3*NUM_STAGES: T+k SHALL read capture data k; T+NUM_TRIG SHALL read hit flags; all other indices SHALL read 0.
REQ-022 rd_req_i in cycle t SHALL produce rd_vld_o = 1 with registered rd_data_o in cycle t+1; reads SHALL be back-to-back capable.
REQ-023 A read SHALL return state as of the end of cycle t, excluding the update made in cycle t.
REQ-024 rd_data_o SHALL be 0 whenever rd_vld_o = 0.
REQ-025 clear_i SHALL take effect next cycle, force all FSMs to IDLE, and have priority over same-cycle events; an in-flight read completes.

Reset
REQ-026 rst SHALL have priority over all inputs.
REQ-027 On rst, all counters, flags, captures and hit bits SHALL become 0, all FSMs IDLE, and rd_vld_o, rd_data_o and status_o SHALL be 0 next cycle.
REQ-028 Assertion of rst during BUSY SHALL discard the measurement.

Structure
REQ-029 The register-index constants, the FSM state enum and the fixed 8-bit select width SHALL reside in a shared debug package.
REQ-030 The per-stage FSM and its counters SHALL be one sub-module, stage_lat_counter, instantiated NUM_STAGES times.

Verification
REQ-031 Bench SHALL check: vld[0] at cycle 10, rdy[0] at cycle 25 -> start_cnt[0] = 1, last_lat[0] = 15, total_busy[0] = 15, status_o[0] = status_o[NUM_STAGES] = 1.
REQ-032 Bench SHALL check: back-to-back vld+rdy in BUSY after lat 5, then rdy 7 later -> start_cnt = 2, last_lat = 7, total = 12.
REQ-033 Bench SHALL check: CNT_W = 8, 300 one-cycle jobs -> start_cnt = 255, total_busy = 255.
REQ-034 Bench SHALL check: trig_addr = 10, probes at addr 10 with data 0xAA then 0xBB -> mode 0 reads 0xAA, mode 1 reads 0xBB, hit bit 1.
REQ-035 Bench SHALL check: clear_i mid-BUSY, then rdy -> orphan set, counters 0, cycle counter non-zero.
REQ-036 Bench SHALL check: rd_sel 0 -> 32'h4741_5401 one cycle after rd_req_i; rd_sel 255 -> 0.

Source files
------------

// File: rtl/stage_debug_pkg.sv
// Shared definitions for the stage debug monitor: register map indices,
// select width and the per-stage FSM state encoding.
package stage_debug_pkg;

    localparam int SEL_W = 8;

    localparam logic [SEL_W-1:0] REG_ID         = 8'd0;
    localparam logic [SEL_W-1:0] REG_FLAGS      = 8'd1;
    localparam logic [SEL_W-1:0] REG_CYCLE      = 8'd2;
    localparam logic [SEL_W-1:0] REG_STAGE_BASE = 8'd3;
    localparam int               REGS_PER_STAGE = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stage_state_e;

endpackage

// File: rtl/stage_lat_counter.sv
// One monitored stage: IDLE/BUSY tracker with saturating start count,
// last latency, accumulated busy time and sticky seen/orphan flags.
module stage_lat_counter
    import stage_debug_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_vld,
    input  logic             i_rdy,
    output logic [CNT_W-1:0] o_start_cnt,
    output logic [CNT_W-1:0] o_last_lat,
    output logic [CNT_W-1:0] o_total_busy,
    output logic             o_vld_seen,
    output logic             o_rdy_seen,
    output logic             o_orphan
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum     = {1'b0, a} + {1'b0, b};
        sat_add = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    stage_state_e     r_state;
    logic [CNT_W-1:0] r_start_cnt;
    logic [CNT_W-1:0] r_last_lat;
    logic [CNT_W-1:0] r_total_busy;
    logic [CNT_W-1:0] r_cur_lat;
    logic             r_vld_seen;
    logic             r_rdy_seen;
    logic             r_orphan;

    logic w_start;
    logic w_close;
    logic w_idle_pair;
    logic w_orphan;

    // Decode this cycle's event from state and strobes
    always_comb begin
        w_start     = i_vld && ((r_state == ST_IDLE) || i_rdy);
        w_close     = (r_state == ST_BUSY) && i_rdy;
        w_idle_pair = (r_state == ST_IDLE) && i_vld && i_rdy;
        w_orphan    = (r_state == ST_IDLE) && i_rdy && !i_vld;
    end

    // Stage state, counters and sticky flags
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_state      <= ST_IDLE;
            r_start_cnt  <= '0;
            r_last_lat   <= '0;
            r_total_busy <= '0;
            r_cur_lat    <= '0;
            r_vld_seen   <= 1'b0;
            r_rdy_seen   <= 1'b0;
            r_orphan     <= 1'b0;
        end else begin
            if (i_vld)    r_vld_seen <= 1'b1;
            if (i_rdy)    r_rdy_seen <= 1'b1;
            if (w_orphan) r_orphan   <= 1'b1;
            if (w_start)  r_start_cnt <= sat_inc(r_start_cnt);
            // A same-cycle vld+rdy while idle is a zero-length job
            if (w_close) begin
                r_last_lat   <= r_cur_lat;
                r_total_busy <= sat_add(r_total_busy, r_cur_lat);
            end else if (w_idle_pair) begin
                r_last_lat <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_vld && !i_rdy) begin
                        r_state   <= ST_BUSY;
                        r_cur_lat <= CNT_ONE;
                    end
                end
                ST_BUSY: begin
                    if (i_rdy && !i_vld) begin
                        r_state <= ST_IDLE;
                    end else if (i_rdy) begin
                        r_cur_lat <= CNT_ONE;
                    end else begin
                        r_cur_lat <= sat_inc(r_cur_lat);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_start_cnt  = r_start_cnt;
    assign o_last_lat   = r_last_lat;
    assign o_total_busy = r_total_busy;
    assign o_vld_seen   = r_vld_seen;
    assign o_rdy_seen   = r_rdy_seen;
    assign o_orphan     = r_orphan;

endmodule

// File: rtl/stage_debug_monitor.sv
// Pipeline debug monitor: per-stage latency statistics, probe capture slots
// and a registered read port over a flat register map.
module stage_debug_monitor
    import stage_debug_pkg::*;
#(
    parameter int          NUM_STAGES = 4,
    parameter int          CNT_W      = 32,
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 16,
    parameter int          NUM_TRIG   = 2,
    parameter logic [31:0] DEBUG_ID   = 32'h4741_5401
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic [NUM_STAGES-1:0]        stage_vld_i,
    input  logic [NUM_STAGES-1:0]        stage_rdy_i,
    input  logic                         probe_en_i,
    input  logic [ADDR_W-1:0]            probe_addr_i,
    input  logic [DATA_W-1:0]            probe_data_i,
    input  logic [NUM_TRIG*ADDR_W-1:0]   trig_addr_i,
    input  logic                         cap_mode_i,
    input  logic [SEL_W-1:0]             rd_sel_i,
    input  logic                         rd_req_i,
    output logic                         rd_vld_o,
    output logic [31:0]                  rd_data_o,
    output logic [2*NUM_STAGES-1:0]      status_o
);

    localparam int T_BASE = 3 + REGS_PER_STAGE * NUM_STAGES;

    logic [CNT_W-1:0]    w_start_cnt  [NUM_STAGES];
    logic [CNT_W-1:0]    w_last_lat   [NUM_STAGES];
    logic [CNT_W-1:0]    w_total_busy [NUM_STAGES];
    logic [NUM_STAGES-1:0] w_vld_seen;
    logic [NUM_STAGES-1:0] w_rdy_seen;
    logic [NUM_STAGES-1:0] w_orphan;
    logic [3*NUM_STAGES-1:0] w_flags;

    logic [31:0]         r_cycle;
    logic [DATA_W-1:0]   r_cap_data [NUM_TRIG];
    logic [NUM_TRIG-1:0] r_hit;
    logic [NUM_TRIG-1:0] w_cap_hit;
    logic                r_rd_vld;
    logic [31:0]         r_rd_data;
    logic [31:0]         w_sel;
    logic [31:0]         w_rd_mux;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        stage_lat_counter #(.CNT_W(CNT_W)) u_stage (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_clear      (clear_i),
            .i_vld        (stage_vld_i[s]),
            .i_rdy        (stage_rdy_i[s]),
            .o_start_cnt  (w_start_cnt[s]),
            .o_last_lat   (w_last_lat[s]),
            .o_total_busy (w_total_busy[s]),
            .o_vld_seen   (w_vld_seen[s]),
            .o_rdy_seen   (w_rdy_seen[s]),
            .o_orphan     (w_orphan[s])
        );
    end

    assign w_flags  = {w_orphan, w_rdy_seen, w_vld_seen};
    assign status_o = {w_rdy_seen, w_vld_seen};

    // Free-running cycle counter; deliberately immune to clear_i
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Slot match: first-hit mode locks the slot after its first capture
    always_comb begin
        w_cap_hit = '0;
        for (int k = 0; k < NUM_TRIG; k++) begin
            w_cap_hit[k] = probe_en_i
                        && (probe_addr_i == trig_addr_i[k*ADDR_W +: ADDR_W])
                        && (cap_mode_i || !r_hit[k]);
        end
    end

    // Capture data and hit flags
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_hit <= '0;
            for (int k = 0; k < NUM_TRIG; k++) begin
                r_cap_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TRIG; k++) begin
                if (w_cap_hit[k]) begin
                    r_cap_data[k] <= probe_data_i;
                    r_hit[k]      <= 1'b1;
                end
            end
        end
    end

    // Register map decode; unmapped indices fall through to zero
    always_comb begin
        w_sel    = {24'd0, rd_sel_i};
        w_rd_mux = 32'd0;
        if (w_sel == 32'(REG_ID)) begin
            w_rd_mux = DEBUG_ID;
        end else if (w_sel == 32'(REG_FLAGS)) begin
            w_rd_mux = 32'(w_flags);
        end else if (w_sel == 32'(REG_CYCLE)) begin
            w_rd_mux = r_cycle;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                w_rd_mux = w_rd_mux
                    | ((w_sel == 32'(3 + 3*s)) ? 32'(w_start_cnt[s])  : 32'd0)
                    | ((w_sel == 32'(4 + 3*s)) ? 32'(w_last_lat[s])   : 32'd0)
                    | ((w_sel == 32'(5 + 3*s)) ? 32'(w_total_busy[s]) : 32'd0);
            end
            for (int k = 0; k < NUM_TRIG; k++) begin
                w_rd_mux = w_rd_mux
                    | ((w_sel == 32'(T_BASE + k)) ? 32'(r_cap_data[k]) : 32'd0);
            end
            w_rd_mux = w_rd_mux
                | ((w_sel == 32'(T_BASE + NUM_TRIG)) ? 32'(r_hit) : 32'd0);
        end
    end

    // Registered read port; data is forced to zero when not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= 32'd0;
        end else if (rd_req_i) begin
            r_rd_vld  <= 1'b1;
            r_rd_data <= w_rd_mux;
        end else begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= 32'd0;
        end
    end

    assign rd_vld_o  = r_rd_vld;
    assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_stage_debug_monitor.sv
// Scoreboard bench: each read pushes its expected value; the monitor pops
// and compares whenever a DUT returns read data.
module tb_stage_debug_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic [3:0]  stage_vld_i;
    logic [3:0]  stage_rdy_i;
    logic        probe_en_i;
    logic [15:0] probe_addr_i;
    logic [31:0] probe_data_i;
    logic [31:0] trig_addr_i;
    logic        cap_mode_i;
    logic [7:0]  rd_sel_i;
    logic        rd_req_i;
    logic        rd_vld_o;
    logic [31:0] rd_data_o;
    logic [7:0]  status_o;

    logic        clear8;
    logic [0:0]  vld8;
    logic [0:0]  rdy8;
    logic [7:0]  sel8;
    logic        req8;
    logic        vld8_o;
    logic [31:0] data8_o;
    logic [1:0]  status8_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] tb_cyc;

    string       q_tag[$];
    logic [31:0] q_exp[$];
    string       q8_tag[$];
    logic [31:0] q8_exp[$];

    always #5 clk = ~clk;

    stage_debug_monitor u_dut (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_i),
        .stage_vld_i  (stage_vld_i),
        .stage_rdy_i  (stage_rdy_i),
        .probe_en_i   (probe_en_i),
        .probe_addr_i (probe_addr_i),
        .probe_data_i (probe_data_i),
        .trig_addr_i  (trig_addr_i),
        .cap_mode_i   (cap_mode_i),
        .rd_sel_i     (rd_sel_i),
        .rd_req_i     (rd_req_i),
        .rd_vld_o     (rd_vld_o),
        .rd_data_o    (rd_data_o),
        .status_o     (status_o)
    );

    stage_debug_monitor #(.NUM_STAGES(1), .CNT_W(8), .NUM_TRIG(1)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear8),
        .stage_vld_i  (vld8),
        .stage_rdy_i  (rdy8),
        .probe_en_i   (1'b0),
        .probe_addr_i (16'd0),
        .probe_data_i (32'd0),
        .trig_addr_i  (16'd0),
        .cap_mode_i   (1'b0),
        .rd_sel_i     (sel8),
        .rd_req_i     (req8),
        .rd_vld_o     (vld8_o),
        .rd_data_o    (data8_o),
        .status_o     (status8_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] sel, input string tag, input logic [31:0] exp);
        rd_sel_i = sel;
        rd_req_i = 1'b1;
        q_tag.push_back(tag);
        q_exp.push_back(exp);
        tick();
        rd_req_i = 1'b0;
    endtask

    task automatic rd8(input logic [7:0] sel, input string tag, input logic [31:0] exp);
        sel8 = sel;
        req8 = 1'b1;
        q8_tag.push_back(tag);
        q8_exp.push_back(exp);
        tick();
        req8 = 1'b0;
    endtask

    // Reference cycle count: reset to zero, increments every clock after
    always @(posedge clk) begin
        if (rst) tb_cyc <= 32'd0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    string       m_tag;
    logic [31:0] m_exp;
    always @(negedge clk) begin
        if (rd_vld_o) begin
            if (q_exp.size() == 0) begin
                check_val("sb_unexpected", 32'(q_exp.size()), 32'd1);
            end else begin
                m_tag = q_tag.pop_front();
                m_exp = q_exp.pop_front();
                check_val(m_tag, rd_data_o, m_exp);
            end
        end
    end

    string       m8_tag;
    logic [31:0] m8_exp;
    always @(negedge clk) begin
        if (vld8_o) begin
            if (q8_exp.size() == 0) begin
                check_val("sb8_unexpected", 32'(q8_exp.size()), 32'd1);
            end else begin
                m8_tag = q8_tag.pop_front();
                m8_exp = q8_exp.pop_front();
                check_val(m8_tag, data8_o, m8_exp);
            end
        end
    end

    initial begin
        rst = 1'b1; clear_i = 1'b0; stage_vld_i = 4'd0; stage_rdy_i = 4'd0;
        probe_en_i = 1'b0; probe_addr_i = 16'd0; probe_data_i = 32'd0;
        trig_addr_i = {16'd20, 16'd10}; cap_mode_i = 1'b0;
        rd_sel_i = 8'd0; rd_req_i = 1'b0;
        clear8 = 1'b0; vld8 = 1'b0; rdy8 = 1'b0; sel8 = 8'd0; req8 = 1'b0;
        repeat (3) tick();
        check_val("rst_rd_vld", {31'd0, rd_vld_o}, 32'd0);
        check_val("rst_rd_data", rd_data_o, 32'd0);
        check_val("rst_status", {24'd0, status_o}, 32'd0);
        rst = 1'b0;
        tick();
        rd(8'd1,  "rst_flags",  32'd0);
        rd(8'd3,  "rst_start0", 32'd0);
        rd(8'd15, "rst_cap0",   32'd0);
        rd(8'd17, "rst_hit",    32'd0);
        repeat (4) tick();

        // Stage 0: single job of latency 15
        stage_vld_i[0] = 1'b1; tick(); stage_vld_i[0] = 1'b0;
        repeat (14) tick();
        stage_rdy_i[0] = 1'b1; tick(); stage_rdy_i[0] = 1'b0;
        check_val("st_vld_seen0", {31'd0, status_o[0]}, 32'd1);
        check_val("st_rdy_seen0", {31'd0, status_o[4]}, 32'd1);
        rd(8'd3, "s0_start", 32'd1);
        rd(8'd4, "s0_last",  32'd15);
        rd(8'd5, "s0_total", 32'd15);

        // Stage 1: restart in BUSY after 5, then close 7 later
        stage_vld_i[1] = 1'b1; tick(); stage_vld_i[1] = 1'b0;
        repeat (4) tick();
        stage_vld_i[1] = 1'b1; stage_rdy_i[1] = 1'b1; tick();
        stage_vld_i[1] = 1'b0; stage_rdy_i[1] = 1'b0;
        repeat (6) tick();
        stage_rdy_i[1] = 1'b1; tick(); stage_rdy_i[1] = 1'b0;
        rd(8'd6, "s1_start", 32'd2);
        rd(8'd7, "s1_last",  32'd7);
        rd(8'd8, "s1_total", 32'd12);

        // Stage 2: latency-3 job, then vld+rdy while idle
        stage_vld_i[2] = 1'b1; tick(); stage_vld_i[2] = 1'b0;
        repeat (2) tick();
        stage_rdy_i[2] = 1'b1; tick(); stage_rdy_i[2] = 1'b0;
        stage_vld_i[2] = 1'b1; stage_rdy_i[2] = 1'b1; tick();
        stage_vld_i[2] = 1'b0; stage_rdy_i[2] = 1'b0;
        rd(8'd9,  "s2_start", 32'd2);
        rd(8'd10, "s2_last",  32'd0);
        rd(8'd11, "s2_total", 32'd3);
        rd(8'd1,  "flags_a",  32'h0000_0077);

        // Stage 3: clear while busy, then rdy arrives as an orphan
        stage_vld_i[3] = 1'b1; tick(); stage_vld_i[3] = 1'b0;
        repeat (3) tick();
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        stage_rdy_i[3] = 1'b1; tick(); stage_rdy_i[3] = 1'b0;
        check_val("st_after_clr", {24'd0, status_o}, 32'h0000_0080);
        rd(8'd1,  "flags_clr",  32'h0000_0880);
        rd(8'd2,  "cycle_cnt",  tb_cyc);
        rd(8'd3,  "s0_start_c", 32'd0);
        rd(8'd8,  "s1_total_c", 32'd0);
        rd(8'd12, "s3_start_c", 32'd0);
        rd(8'd13, "s3_last_c",  32'd0);
        rd(8'd14, "s3_total_c", 32'd0);
        check_val("cycle_nonzero", {31'd0, (tb_cyc != 32'd0)}, 32'd1);

        // Capture: first-hit mode keeps 0xAA
        probe_en_i = 1'b1; probe_addr_i = 16'd10; probe_data_i = 32'hAA; tick();
        probe_data_i = 32'hBB; tick();
        probe_en_i = 1'b0;
        rd(8'd15, "cap0_first", 32'h0000_00AA);
        rd(8'd16, "cap1_none",  32'd0);
        rd(8'd17, "hit_first",  32'd1);

        // Capture: last-hit mode, both slots on the same address
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        cap_mode_i = 1'b1; trig_addr_i = {16'd10, 16'd10};
        probe_en_i = 1'b1; probe_data_i = 32'hAA; tick();
        probe_data_i = 32'hBB; tick();
        probe_en_i = 1'b0; probe_data_i = 32'hCC; tick();
        rd(8'd15, "cap0_last", 32'h0000_00BB);
        rd(8'd16, "cap1_last", 32'h0000_00BB);
        rd(8'd17, "hit_last",  32'd3);
        rd(8'd18, "unmapped",  32'd0);
        rd(8'd0,  "debug_id",  32'h4741_5401);
        check_val("rd_latency", {31'd0, rd_vld_o}, 32'd1);
        rd(8'd255, "sel_255",  32'd0);

        // 8-bit counters: 300 one-cycle jobs must saturate
        for (int j = 0; j < 300; j++) begin
            vld8 = 1'b1; tick(); vld8 = 1'b0;
            rdy8 = 1'b1; tick(); rdy8 = 1'b0;
        end
        rd8(8'd3, "sat_start", 32'd255);
        rd8(8'd4, "sat_last",  32'd1);
        rd8(8'd5, "sat_total", 32'd255);

        repeat (4) tick();
        check_val("sb_drain",  32'(q_exp.size()),  32'd0);
        check_val("sb8_drain", 32'(q8_exp.size()), 32'd0);
        check_val("rd_idle_zero", rd_data_o, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
